// File: rtl/apb_multi_pkg.sv
// Shared types and helpers for the APB4 multi-slave requester.
// State encoding, slave-index width function and default widths.
package apb_multi_pkg;

    localparam int unsigned DefaultAw      = 32;
    localparam int unsigned DefaultDw      = 32;
    localparam int unsigned DefaultNumSlv  = 2;
    localparam int unsigned DefaultSelLsb  = 3;
    localparam int unsigned DefaultTimeout = 255;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StDecErr
    } state_e;

    // A single slave still needs a one-bit index field.
    function automatic int unsigned calc_iw(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/apb_slave_decode.sv
// Combinational slave decoder: extracts the slave index from the address,
// produces the one-hot select and flags whether the index maps to a slave.
module apb_slave_decode
    import apb_multi_pkg::*;
#(
    parameter int unsigned AW      = DefaultAw,
    parameter int unsigned NUM_SLV = DefaultNumSlv,
    parameter int unsigned SEL_LSB = DefaultSelLsb,
    parameter int unsigned IW      = calc_iw(NUM_SLV)
) (
    input  logic [AW-1:0]      addr,
    output logic [IW-1:0]      idx,
    output logic [NUM_SLV-1:0] sel,
    output logic               in_range
);

    // Only the index field matters; the rest of the address is routed elsewhere.
    logic unused_addr;
    assign unused_addr = ^addr;

    always_comb begin
        idx      = addr[SEL_LSB +: IW];
        in_range = (32'(idx) < NUM_SLV);
        sel      = '0;
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
            sel[i] = in_range && (32'(idx) == i);
        end
    end

endmodule

// File: rtl/apb_multi_master.sv
// APB4 requester: valid/ready request port to SETUP/ACCESS transfers on NUM_SLV slaves.
// Optional ACCESS wait timeout is enabled by defining APB_TIMEOUT_EN.
module apb_multi_master
    import apb_multi_pkg::*;
#(
    parameter int unsigned AW          = DefaultAw,
    parameter int unsigned DW          = DefaultDw,
    parameter int unsigned NUM_SLV     = DefaultNumSlv,
    parameter int unsigned SEL_LSB     = DefaultSelLsb,
    parameter int unsigned TIMEOUT_CYC = DefaultTimeout
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [AW-1:0]         req_addr,
    input  logic [DW-1:0]         req_wdata,
    input  logic [DW/8-1:0]       req_strb,
    output logic                  rsp_valid,
    output logic [DW-1:0]         rsp_rdata,
    output logic                  rsp_err,
    output logic [AW-1:0]         PADDR,
    output logic [NUM_SLV-1:0]    PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [DW-1:0]         PWDATA,
    output logic [DW/8-1:0]       PSTRB,
    input  logic [NUM_SLV*DW-1:0] PRDATA,
    input  logic [NUM_SLV-1:0]    PREADY,
    input  logic [NUM_SLV-1:0]    PSLVERR
);

    localparam int unsigned IW = calc_iw(NUM_SLV);
    localparam int unsigned SW = DW / 8;

    state_e state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;

    logic [AW-1:0]      paddr_d;
    logic [NUM_SLV-1:0] psel_d;
    logic               penable_d;
    logic               pwrite_d;
    logic [DW-1:0]      pwdata_d;
    logic [SW-1:0]      pstrb_d;
    logic               rsp_valid_d;
    logic [DW-1:0]      rsp_rdata_d;
    logic               rsp_err_d;

    logic [IW-1:0]      dec_idx;
    logic [NUM_SLV-1:0] dec_sel;
    logic               dec_in_range;

    logic          sel_ready;
    logic          sel_err;
    logic [DW-1:0] sel_rdata;
    logic          timeout;

    apb_slave_decode #(
        .AW      (AW),
        .NUM_SLV (NUM_SLV),
        .SEL_LSB (SEL_LSB),
        .IW      (IW)
    ) u_decode (
        .addr     (req_addr),
        .idx      (dec_idx),
        .sel      (dec_sel),
        .in_range (dec_in_range)
    );

    assign req_ready = (state_q == StIdle);

    // Responses of unselected slaves never reach the datapath.
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
            if (32'(idx_q) == i) begin
                sel_ready = PREADY[i];
                sel_err   = PSLVERR[i];
                sel_rdata = PRDATA[i*DW +: DW];
            end
        end
    end

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CntW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

    logic [CntW-1:0] wait_cnt_q;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wait_cnt_q <= '0;
        end else if (state_q == StSetup) begin
            wait_cnt_q <= '0;
        end else if (state_q == StAccess && !sel_ready) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end
    end

    // Fires on the wait cycle that brings the counter up to TIMEOUT_CYC.
    assign timeout = (state_q == StAccess) && !sel_ready &&
                     ((wait_cnt_q + 1'b1) == CntW'(TIMEOUT_CYC));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^32'(TIMEOUT_CYC);
    assign timeout = 1'b0;
`endif

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            PADDR     <= '0;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            PSTRB     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            PADDR     <= paddr_d;
            PSEL      <= psel_d;
            PENABLE   <= penable_d;
            PWRITE    <= pwrite_d;
            PWDATA    <= pwdata_d;
            PSTRB     <= pstrb_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    state_d = dec_in_range ? StSetup : StDecErr;
                end
            end
            StSetup:  state_d = StAccess;
            StAccess: begin
                if (sel_ready || timeout) begin
                    state_d = StIdle;
                end
            end
            StDecErr: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        idx_d       = idx_q;
        paddr_d     = PADDR;
        psel_d      = PSEL;
        penable_d   = PENABLE;
        pwrite_d    = PWRITE;
        pwdata_d    = PWDATA;
        pstrb_d     = PSTRB;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;
        unique case (state_q)
            StIdle: begin
                if (req_valid && dec_in_range) begin
                    idx_d    = dec_idx;
                    psel_d   = dec_sel;
                    paddr_d  = req_addr;
                    pwrite_d = req_write;
                    pstrb_d  = req_write ? req_strb : '0;
                    if (req_write) begin
                        pwdata_d = req_wdata;
                    end
                end
            end
            StSetup: penable_d = 1'b1;
            StAccess: begin
                if (sel_ready || timeout) begin
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = sel_ready ? sel_err : 1'b1;
                    rsp_rdata_d = (sel_ready && !PWRITE) ? sel_rdata : '0;
                end
            end
            StDecErr: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
                rsp_rdata_d = '0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_apb_multi_master.sv
// Scoreboard bench for apb_multi_master with three scripted APB slaves.
// Define APB_TIMEOUT_EN to exercise the ACCESS timeout path.
module tb_apb_multi_master;

    localparam int unsigned NS = 3;

    logic            PCLK = 1'b0;
    logic            PRESET;
    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    logic [31:0]     req_addr;
    logic [31:0]     req_wdata;
    logic [3:0]      req_strb;
    logic            rsp_valid;
    logic [31:0]     rsp_rdata;
    logic            rsp_err;
    logic [31:0]     PADDR;
    logic [NS-1:0]   PSEL;
    logic            PENABLE;
    logic            PWRITE;
    logic [31:0]     PWDATA;
    logic [3:0]      PSTRB;
    logic [NS*32-1:0] PRDATA;
    logic [NS-1:0]   PREADY;
    logic [NS-1:0]   PSLVERR;

    apb_multi_master #(
        .AW          (32),
        .DW          (32),
        .NUM_SLV     (NS),
        .SEL_LSB     (3),
        .TIMEOUT_CYC (8)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_strb  (req_strb),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PADDR     (PADDR),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PSTRB     (PSTRB),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    // Scripted slaves: ready after wait_cfg ACCESS cycles when enabled.
    logic [NS-1:0] rdy_en;
    logic [NS-1:0] err_cfg;
    int unsigned   wait_cfg [NS];
    logic [31:0]   rd_cfg [NS];
    int unsigned   acc_cnt = 0;

    always @(posedge PCLK) acc_cnt <= (PENABLE && (|PSEL)) ? acc_cnt + 1 : 0;

    always_comb begin
        PREADY  = '0;
        PSLVERR = '0;
        PRDATA  = '0;
        for (int i = 0; i < NS; i++) begin
            PREADY[i]          = rdy_en[i] && (acc_cnt >= wait_cfg[i]);
            PSLVERR[i]         = err_cfg[i];
            PRDATA[i*32 +: 32] = rd_cfg[i];
        end
    end

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned n_rsp = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every response pulse is matched against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge PCLK);
            if (rsp_valid) begin
                n_rsp++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1, expected none at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                end
            end
        end
    end

    // Returns just after the handshake edge (cycle 0).
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb);
        int unsigned t;
        t = 0;
        @(negedge PCLK);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_strb  = strb;
        while (!req_ready && t < 50) begin
            @(negedge PCLK);
            t++;
        end
        if (!req_ready) chk("handshake_wait", 32'(req_ready), 32'd1);
        @(posedge PCLK);
        #1;
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned en_cnt;
        int unsigned seen;
        int unsigned rsp0;

        PRESET    = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_strb  = '0;
        rdy_en    = '1;
        err_cfg   = '0;
        for (int i = 0; i < NS; i++) begin
            wait_cfg[i] = 0;
            rd_cfg[i]   = 32'h0;
        end
        repeat (3) @(posedge PCLK);
        #1 PRESET = 1'b0;
        @(negedge PCLK);

        chk("rst_psel", 32'(PSEL), 32'd0);
        chk("rst_penable", 32'(PENABLE), 32'd0);
        chk("rst_pwrite", 32'(PWRITE), 32'd0);
        chk("rst_paddr", PADDR, 32'd0);
        chk("rst_pwdata", PWDATA, 32'd0);
        chk("rst_pstrb", 32'(PSTRB), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);

        // Zero-wait write to slave 1; slave 0 asserting PSLVERR must be ignored.
        err_cfg = 3'b001;
        exp_q.push_back('{rdata: 32'h0, err: 1'b0});
        issue(1'b1, 32'h08, 32'hDEADBEEF, 4'b0011);
        @(negedge PCLK);
        chk("wr_c1_psel", 32'(PSEL), 32'b010);
        chk("wr_c1_penable", 32'(PENABLE), 32'd0);
        chk("wr_c1_pstrb", 32'(PSTRB), 32'b0011);
        chk("wr_c1_pwrite", 32'(PWRITE), 32'd1);
        chk("wr_c1_paddr", PADDR, 32'h08);
        chk("wr_c1_pwdata", PWDATA, 32'hDEADBEEF);
        chk("wr_c1_req_ready", 32'(req_ready), 32'd0);
        @(negedge PCLK);
        chk("wr_c2_psel", 32'(PSEL), 32'b010);
        chk("wr_c2_penable", 32'(PENABLE), 32'd1);
        chk("wr_c2_pstrb", 32'(PSTRB), 32'b0011);
        @(negedge PCLK);
        chk("wr_c3_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("wr_c3_psel", 32'(PSEL), 32'd0);
        chk("wr_c3_penable", 32'(PENABLE), 32'd0);
        chk("wr_c3_req_ready", 32'(req_ready), 32'd1);
        @(negedge PCLK);
        chk("wr_c4_rsp_pulse", 32'(rsp_valid), 32'd0);
        err_cfg = '0;

        // Read from slave 0 with 4 wait states.
        wait_cfg[0] = 4;
        rd_cfg[0]   = 32'h12345678;
        rd_cfg[1]   = 32'hAAAA5555;
        exp_q.push_back('{rdata: 32'h12345678, err: 1'b0});
        issue(1'b0, 32'h00, 32'h11111111, 4'b1111);
        @(negedge PCLK);
        chk("rd_c1_psel", 32'(PSEL), 32'b001);
        chk("rd_c1_pstrb", 32'(PSTRB), 32'd0);
        chk("rd_c1_pwrite", 32'(PWRITE), 32'd0);
        chk("rd_c1_pwdata_hold", PWDATA, 32'hDEADBEEF);
        en_cnt = 0;
        seen   = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge PCLK);
            if (rsp_valid) begin
                seen = 1;
                break;
            end
            if (PENABLE) en_cnt++;
        end
        chk("rd_rsp_seen", seen, 32'd1);
        chk("rd_penable_cycles", en_cnt, 32'd5);
        wait_cfg[0] = 0;

        // Unmapped index 3 completes with a decode error and no APB activity.
        exp_q.push_back('{rdata: 32'h0, err: 1'b1});
        issue(1'b1, 32'h18, 32'h00000055, 4'b1111);
        @(negedge PCLK);
        chk("dec_c1_psel", 32'(PSEL), 32'd0);
        chk("dec_c1_penable", 32'(PENABLE), 32'd0);
        chk("dec_c1_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge PCLK);
        chk("dec_c2_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("dec_c2_psel", 32'(PSEL), 32'd0);
        chk("dec_c2_pwdata", PWDATA, 32'hDEADBEEF);

        // Slave error on a write followed back-to-back by a read from slave 2.
        err_cfg   = 3'b010;
        rd_cfg[2] = 32'hCAFEF00D;
        rsp0      = n_rsp;
        exp_q.push_back('{rdata: 32'h0, err: 1'b1});
        exp_q.push_back('{rdata: 32'hCAFEF00D, err: 1'b0});
        issue(1'b1, 32'h08, 32'h0BADF00D, 4'b1100);
        issue(1'b0, 32'h10, 32'h0, 4'b0000);
        repeat (8) @(negedge PCLK);
        chk("b2b_rsp_count", n_rsp - rsp0, 32'd2);
        err_cfg = '0;

        // Reset for 2 cycles in the middle of ACCESS abandons the transfer.
        rdy_en[0] = 1'b0;
        issue(1'b0, 32'h00, 32'h0, 4'b0000);
        repeat (3) @(negedge PCLK);
        chk("rst_mid_penable_before", 32'(PENABLE), 32'd1);
        PRESET = 1'b1;
        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;
        chk("rst_mid_psel", 32'(PSEL), 32'd0);
        chk("rst_mid_penable", 32'(PENABLE), 32'd0);
        chk("rst_mid_req_ready", 32'(req_ready), 32'd1);
        chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        rdy_en[0] = 1'b1;
        repeat (5) @(negedge PCLK);

        // Slave 1 never answers.
        rdy_en[1] = 1'b0;
`ifdef APB_TIMEOUT_EN
        exp_q.push_back('{rdata: 32'h0, err: 1'b1});
        issue(1'b1, 32'h08, 32'h01020304, 4'b1111);
        en_cnt = 0;
        seen   = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge PCLK);
            if (rsp_valid) begin
                seen = 1;
                break;
            end
            if (PENABLE) en_cnt++;
        end
        chk("to_rsp_seen", seen, 32'd1);
        chk("to_access_cycles", en_cnt, 32'd8);
        chk("to_psel_drop", 32'(PSEL), 32'd0);
`else
        issue(1'b1, 32'h08, 32'h01020304, 4'b1111);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge PCLK);
            if (rsp_valid) seen++;
        end
        chk("hang_no_rsp", seen, 32'd0);
        chk("hang_penable", 32'(PENABLE), 32'd1);
        chk("hang_psel", 32'(PSEL), 32'b010);
        PRESET = 1'b1;
        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;
`endif
        rdy_en[1] = 1'b1;
        repeat (4) @(negedge PCLK);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
